mips_ram_arbiter: RTL

- Shares the single 16-bit asynchronous Ram between the Mips instruction-fetch port and data-memory port.
- Arbitrates between the two requesters, splits each 32-bit access into big-endian halfword RAM cycles and generates the RAM chip controls.
- Sits between the core's memory interfaces and the Ram pins (addr, data, wre, oute, hb_mask, lb_mask, chip_en); the top level merges the data in/out/oe triple onto the inout data bus.

---
 rtl/mips_ram_arbiter_pkg.sv | 12 +
 rtl/mips_ram_arbiter_if.sv | 37 +++
 rtl/mips_ram_arbiter_rr.sv | 25 ++
 rtl/mips_ram_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mips_ram_arbiter_pkg.sv
// Shared types and constants for the Mips 16-bit RAM arbiter slice.
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, HI, LO, ACK} state_t;
  typedef enum logic {PORT_IF = 1'b0, PORT_DM = 1'b1} port_t;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BE_W   = 4;

  localparam logic RAM_ON  = 1'b0;
  localparam logic RAM_OFF = 1'b1;
endpackage

// File: rtl/mips_ram_arbiter_if.sv
// Core-side request ports plus RAM pin triple; slave = arbiter, master = core/RAM side.
interface mips_ram_arbiter_if
  import mips_mem_pkg::*;
#(parameter int RAM_AW = 18);
  logic              if_req;
  logic [RAM_AW:0]   if_addr;
  logic [WORD_W-1:0] if_rdata;
  logic              if_ack;
  logic              dm_req;
  logic              dm_we;
  logic [RAM_AW:0]   dm_addr;
  logic [WORD_W-1:0] dm_wdata;
  logic [BE_W-1:0]   dm_be;
  logic [WORD_W-1:0] dm_rdata;
  logic              dm_ack;
  logic              err;
  logic [RAM_AW-1:0] ram_addr;
  logic [HALF_W-1:0] ram_dout;
  logic [HALF_W-1:0] ram_din;
  logic              ram_doe;
  logic              ram_wre;
  logic              ram_oute;
  logic              ram_hb_mask;
  logic              ram_lb_mask;
  logic              ram_chip_en;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, ram_din,
    input  if_rdata, if_ack, dm_rdata, dm_ack, err, ram_addr, ram_dout, ram_doe,
           ram_wre, ram_oute, ram_hb_mask, ram_lb_mask, ram_chip_en
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, ram_din,
    output if_rdata, if_ack, dm_rdata, dm_ack, err, ram_addr, ram_dout, ram_doe,
           ram_wre, ram_oute, ram_hb_mask, ram_lb_mask, ram_chip_en
  );
endinterface

// File: rtl/mips_ram_arbiter_rr.sv
// Two-way round-robin picker; last_grant advances only when en and a request is granted.
module rr_arbiter2
  import mips_mem_pkg::*;
(
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic       vld,
  output port_t      gnt
);
  port_t last_q;

  always_comb begin
    vld = |req;
    gnt = PORT_IF;
    if (req[0] && req[1]) gnt = (last_q == PORT_IF) ? PORT_DM : PORT_IF;
    else if (req[1])      gnt = PORT_DM;
  end

  // DM out of reset so IF wins the first tie
  always_ff @(posedge gclk or negedge grst_n)
    if (!grst_n)          last_q <= PORT_DM;
    else if (en && vld)   last_q <= gnt;
endmodule

// File: rtl/mips_ram_arbiter.sv
// IF/DM arbiter for a 16-bit async RAM: big-endian HI/LO halfword cycles per word.
// Optional RAM_ARB_ALIGN_CHECK_EN: misaligned word accesses ack with err and no RAM cycle.
module mips_ram_arbiter
  import mips_mem_pkg::*;
#(
  parameter int RAM_AW      = 18,
  parameter int WAIT_STATES = 0
) (
  input logic               clock,
  input logic               reset,
  mips_ram_arbiter_if.slave bus
);
  localparam logic [2:0] LAST_CNT = 3'(WAIT_STATES);

  state_t              state_q, state_d;
  port_t               port_q, gnt;
  logic                gnt_vld, grant, we_q, mis, last;
  logic [RAM_AW-1:0]   base_q;
  logic [WORD_W-1:0]   wdata_q, word_q;
  logic [BE_W-1:0]     be_q;
  logic [2:0]          cnt_q;
  logic [RAM_AW:0]     sel_addr;
  logic                sel_we;
  logic [BE_W-1:0]     sel_be;
  logic                if_ack, dm_ack;

  rr_arbiter2 u_arb (
    .gclk(clock), .grst_n(reset), .req({bus.dm_req, bus.if_req}),
    .en(state_q == IDLE), .vld(gnt_vld), .gnt(gnt)
  );

  assign grant    = (state_q == IDLE) && gnt_vld;
  assign sel_addr = (gnt == PORT_DM) ? bus.dm_addr : bus.if_addr;
  assign sel_we   = (gnt == PORT_DM) && bus.dm_we;
  assign sel_be   = (gnt == PORT_DM) ? bus.dm_be : 4'hF;
  assign last     = (cnt_q == LAST_CNT);

`ifdef RAM_ARB_ALIGN_CHECK_EN
  logic err_q;
  // sub-word writes may legitimately target any byte lane
  assign mis = (sel_addr[1:0] != 2'b00) && (!sel_we || sel_be == 4'hF);
  always_ff @(posedge clock or negedge reset)
    if (!reset)     err_q <= 1'b0;
    else if (grant) err_q <= mis;
  assign bus.err = (state_q == ACK) && err_q;
`else
  wire unused_lo = ^sel_addr[1:0];
  assign mis     = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (gnt_vld) begin
        if (mis || (sel_we && sel_be == 4'h0)) state_d = ACK;
        else if (sel_we && sel_be[3:2] == 2'b00) state_d = LO;
        else                                     state_d = HI;
      end
      HI:  if (last) state_d = (we_q && be_q[1:0] == 2'b00) ? ACK : LO;
      LO:  if (last) state_d = ACK;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= ((state_q == HI || state_q == LO) && !last) ? cnt_q + 3'd1 : 3'd0;
      if (grant) begin
        port_q  <= gnt;
        we_q    <= sel_we;
        base_q  <= {sel_addr[RAM_AW:2], 1'b0};
        wdata_q <= bus.dm_wdata;
        be_q    <= sel_be;
        word_q  <= '0;
      end
      if (state_q == HI && last && !we_q) word_q[31:16] <= bus.ram_din;
      if (state_q == LO && last && !we_q) word_q[15:0]  <= bus.ram_din;
    end

  // controls decode straight from state so an async reset drops them at once
  always_comb begin
    bus.ram_addr    = '0;
    bus.ram_dout    = '0;
    bus.ram_doe     = 1'b0;
    bus.ram_wre     = RAM_OFF;
    bus.ram_oute    = RAM_OFF;
    bus.ram_hb_mask = RAM_OFF;
    bus.ram_lb_mask = RAM_OFF;
    bus.ram_chip_en = RAM_OFF;
    if (state_q == HI || state_q == LO) begin
      bus.ram_chip_en = RAM_ON;
      bus.ram_addr    = (state_q == HI) ? base_q : (base_q | RAM_AW'(1));
      if (we_q) begin
        bus.ram_wre     = RAM_ON;
        bus.ram_doe     = 1'b1;
        bus.ram_dout    = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
        bus.ram_hb_mask = ~((state_q == HI) ? be_q[3] : be_q[1]);
        bus.ram_lb_mask = ~((state_q == HI) ? be_q[2] : be_q[0]);
      end else begin
        bus.ram_oute    = RAM_ON;
        bus.ram_hb_mask = RAM_ON;
        bus.ram_lb_mask = RAM_ON;
      end
    end
  end

  assign if_ack       = (state_q == ACK) && (port_q == PORT_IF);
  assign dm_ack       = (state_q == ACK) && (port_q == PORT_DM);
  assign bus.if_ack   = if_ack;
  assign bus.dm_ack   = dm_ack;
  assign bus.if_rdata = if_ack ? word_q : '0;
  assign bus.dm_rdata = dm_ack ? word_q : '0;
endmodule
